// File: rtl/alu_pkg.sv
// Shared EX-path types: adder-result op codes, exception codes and
// the registered result bundle handed from the EX result stage to MEM.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD_TRAP   = 3'd0,
    OP_ADD_NOTRAP = 3'd1,
    OP_SLT        = 3'd2,
    OP_BEQ        = 3'd3,
    OP_BNE        = 3'd4
  } op_e;

  localparam logic [4:0] EXCCODE_OV = 5'd12;

  typedef struct packed {
    logic [31:0] result;
    logic [4:0]  rd;
    logic        we;
    logic        br_taken;
  } res_t;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_TRAP = 1'b1
  } state_e;

endpackage

// File: rtl/ex_result_stage_result_fmt.sv
// Combinational op/flag to result-bundle mapping plus trap decision.
// In: op, s, zero, overflow, negative, rd. Out: res bundle, trap.
module result_fmt
  import alu_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] s,
  input  logic        zero,
  input  logic        overflow,
  input  logic        negative,
  input  logic [4:0]  rd,
  output res_t        res,
  output logic        trap
);

  logic is_trap;
  logic is_slt;
  logic is_beq;
  logic is_bne;

  assign is_trap = (op == OP_ADD_TRAP);
  assign is_slt  = (op == OP_SLT);
  assign is_beq  = (op == OP_BEQ);
  assign is_bne  = (op == OP_BNE);

  always_comb begin
    res          = '0;
    res.rd       = rd;
    res.result   = s;
    res.we       = 1'b1;
    res.br_taken = 1'b0;
    unique case (1'b1)
      is_slt: begin
        // sign of A-B already corrected by the adder
        res.result = {31'b0, negative};
      end
      is_beq: begin
        res.we       = 1'b0;
        res.br_taken = zero;
      end
      is_bne: begin
        res.we       = 1'b0;
        res.br_taken = ~zero;
      end
      default: begin
        // ADD_TRAP, ADD_NOTRAP and unused codes 5-7 write the sum
        res.we = 1'b1;
      end
    endcase
  end

  assign trap = is_trap & overflow;

endmodule

// File: rtl/ex_result_stage.sv
// EX result stage: registers adder result for MEM, raises overflow trap.
// Ports: in_valid/in_ready upstream, out_* downstream, exc_* + ov_count.
module ex_result_stage
  import alu_pkg::*;
#(
  parameter logic [4:0] EXC_OV = EXCCODE_OV,
  parameter int         CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      s,
  input  logic             zero,
  input  logic             overflow,
  input  logic             negative,
  input  logic [2:0]       op,
  input  logic [31:0]      pc,
  input  logic [4:0]       rd,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [4:0]       out_rd,
  output logic             out_we,
  output logic             br_taken,
  output logic             exc_valid,
  output logic [31:0]      exc_epc,
  output logic [4:0]       exc_cause,
  output logic [CNT_W-1:0] ov_count
);

  state_e state;
  res_t   fmt;
  logic   trap;
  logic   accept;

  result_fmt u_fmt (
    .op       (op),
    .s        (s),
    .zero     (zero),
    .overflow (overflow),
    .negative (negative),
    .rd       (rd),
    .res      (fmt),
    .trap     (trap)
  );

  assign in_ready = (state == ST_RUN)
                  & (~out_valid | out_ready);
  assign accept   = in_valid & in_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_RUN;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_rd     <= '0;
      out_we     <= 1'b0;
      br_taken   <= 1'b0;
      exc_valid  <= 1'b0;
      exc_epc    <= '0;
      exc_cause  <= '0;
      ov_count   <= '0;
    end else if (flush) begin
      // flush beats any input presented in the same cycle
      state     <= ST_RUN;
      out_valid <= 1'b0;
      exc_valid <= 1'b0;
    end else if (accept) begin
      if (trap) begin
        out_valid <= 1'b0;
        exc_valid <= 1'b1;
        exc_epc   <= pc;
        exc_cause <= EXC_OV;
        state     <= ST_TRAP;
        if (ov_count != '1) begin
          ov_count <= ov_count + 1'b1;
        end
      end else begin
        out_valid  <= 1'b1;
        out_result <= fmt.result;
        out_rd     <= fmt.rd;
        out_we     <= fmt.we;
        br_taken   <= fmt.br_taken;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ex_result_stage.sv
// Directed bench for ex_result_stage: handshake, ops, trap, flush, reset.
// Inputs change 1ns after the rising edge; outputs sampled there too.
module tb_ex_result_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] s;
  logic        zero;
  logic        overflow;
  logic        negative;
  logic [2:0]  op;
  logic [31:0] pc;
  logic [4:0]  rd;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_rd;
  logic        out_we;
  logic        br_taken;
  logic        exc_valid;
  logic [31:0] exc_epc;
  logic [4:0]  exc_cause;
  logic [15:0] ov_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ex_result_stage dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .s          (s),
    .zero       (zero),
    .overflow   (overflow),
    .negative   (negative),
    .op         (op),
    .pc         (pc),
    .rd         (rd),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_rd     (out_rd),
    .out_we     (out_we),
    .br_taken   (br_taken),
    .exc_valid  (exc_valid),
    .exc_epc    (exc_epc),
    .exc_cause  (exc_cause),
    .ov_count   (ov_count)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] o,
                       input logic [31:0] sv, input logic z,
                       input logic ov, input logic n,
                       input logic [31:0] p, input logic [4:0] r);
    in_valid = v;
    op       = o;
    s        = sv;
    zero     = z;
    overflow = ov;
    negative = n;
    pc       = p;
    rd       = r;
  endtask

  initial begin
    reset     = 1'b1;
    flush     = 1'b0;
    out_ready = 1'b1;
    drive(0, 3'd1, 32'h0, 0, 0, 0, 32'h0, 5'd0);
    step();
    step();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_exc_valid", 32'(exc_valid), 32'd0);
    chk("rst_result", out_result, 32'd0);
    chk("rst_ov_count", 32'(ov_count), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    reset = 1'b0;
    step();

    // ADD_NOTRAP
    drive(1, 3'd1, 32'h5, 0, 0, 0, 32'h100, 5'd3);
    step();
    chk("addu_valid", 32'(out_valid), 32'd1);
    chk("addu_result", out_result, 32'h5);
    chk("addu_we", 32'(out_we), 32'd1);
    chk("addu_rd", 32'(out_rd), 32'd3);
    chk("addu_br", 32'(br_taken), 32'd0);
    chk("addu_in_ready", 32'(in_ready), 32'd1);

    // op 5 behaves as ADD_NOTRAP; overflow wraps, no trap
    drive(1, 3'd5, 32'h7, 0, 1, 0, 32'h104, 5'd4);
    step();
    chk("op5_valid", 32'(out_valid), 32'd1);
    chk("op5_result", out_result, 32'h7);
    chk("op5_exc", 32'(exc_valid), 32'd0);

    // ADD_TRAP without overflow writes normally
    drive(1, 3'd0, 32'h0000_1000, 0, 0, 0, 32'h108, 5'd5);
    step();
    chk("add_noov_result", out_result, 32'h1000);
    chk("add_noov_we", 32'(out_we), 32'd1);
    chk("add_noov_exc", 32'(exc_valid), 32'd0);

    // SLT
    drive(1, 3'd2, 32'hFFFF_FFFE, 0, 0, 1, 32'h10C, 5'd6);
    step();
    chk("slt_result", out_result, 32'h1);
    chk("slt_we", 32'(out_we), 32'd1);

    // BEQ taken
    drive(1, 3'd3, 32'h0, 1, 0, 0, 32'h110, 5'd0);
    step();
    chk("beq_br", 32'(br_taken), 32'd1);
    chk("beq_we", 32'(out_we), 32'd0);

    // BNE with zero=1: not taken
    drive(1, 3'd4, 32'h0, 1, 0, 0, 32'h114, 5'd0);
    step();
    chk("bne_z_br", 32'(br_taken), 32'd0);
    chk("bne_z_we", 32'(out_we), 32'd0);

    // BNE with zero=0: taken
    drive(1, 3'd4, 32'h3, 0, 0, 0, 32'h118, 5'd0);
    step();
    chk("bne_nz_br", 32'(br_taken), 32'd1);

    // Backpressure
    drive(1, 3'd1, 32'h1234, 0, 0, 0, 32'h11C, 5'd9);
    step();
    chk("bp_first", out_result, 32'h1234);
    out_ready = 1'b0;
    drive(1, 3'd1, 32'hAAAA, 0, 0, 0, 32'h120, 5'd10);
    #1;
    chk("bp_in_ready0", 32'(in_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      chk("bp_hold_result", out_result, 32'h1234);
      chk("bp_hold_rd", 32'(out_rd), 32'd9);
      chk("bp_hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", 32'(in_ready), 32'd1);
    step();
    chk("bp_next_result", out_result, 32'hAAAA);
    chk("bp_next_rd", 32'(out_rd), 32'd10);

    // flush wins over in_valid
    flush = 1'b1;
    drive(1, 3'd1, 32'h55, 0, 0, 0, 32'h124, 5'd11);
    step();
    flush = 1'b0;
    drive(0, 3'd1, 32'h0, 0, 0, 0, 32'h0, 5'd0);
    chk("flush_valid", 32'(out_valid), 32'd0);
    step();
    chk("flush_valid2", 32'(out_valid), 32'd0);

    // Overflow trap
    drive(1, 3'd0, 32'h8000_0000, 0, 1, 0, 32'h0040_0010, 5'd12);
    step();
    chk("trap_exc_valid", 32'(exc_valid), 32'd1);
    chk("trap_epc", exc_epc, 32'h0040_0010);
    chk("trap_cause", 32'(exc_cause), 32'd12);
    chk("trap_out_valid", 32'(out_valid), 32'd0);
    chk("trap_ov_count", 32'(ov_count), 32'd1);
    chk("trap_in_ready", 32'(in_ready), 32'd0);
    drive(1, 3'd1, 32'h9, 0, 0, 0, 32'h0040_0014, 5'd13);
    step();
    chk("trap_block_valid", 32'(out_valid), 32'd0);
    chk("trap_hold_exc", 32'(exc_valid), 32'd1);
    chk("trap_hold_epc", exc_epc, 32'h0040_0010);
    chk("trap_hold_cnt", 32'(ov_count), 32'd1);
    drive(0, 3'd1, 32'h0, 0, 0, 0, 32'h0, 5'd0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("trap_flush_exc", 32'(exc_valid), 32'd0);
    chk("trap_flush_in_ready", 32'(in_ready), 32'd1);
    chk("trap_flush_cnt", 32'(ov_count), 32'd1);

    // Second trap then async reset mid-TRAP
    drive(1, 3'd0, 32'h7FFF_FFFF, 0, 1, 0, 32'h0040_0020, 5'd1);
    step();
    drive(0, 3'd1, 32'h0, 0, 0, 0, 32'h0, 5'd0);
    chk("trap2_cnt", 32'(ov_count), 32'd2);
    chk("trap2_epc", exc_epc, 32'h0040_0020);
    #2;
    reset = 1'b1;
    #1;
    chk("rst_mid_exc", 32'(exc_valid), 32'd0);
    chk("rst_mid_cnt", 32'(ov_count), 32'd0);
    step();
    reset = 1'b0;
    #1;
    chk("rst_mid_in_ready", 32'(in_ready), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
